// File: rtl/ddr3_dfi_responder_pkg.sv
// Shared DDR3 command encodings and error-flag indices for the DFI responder
// and the memory controller that drives it.
package ddr3_dfi_responder_pkg;

    // Decode key is {ras_n, cas_n, we_n}; every code is listed so casts are total.
    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_RSV = 3'b110,
        CMD_NOP = 3'b111
    } ddr_cmd_e;

    localparam int ERR_BITS       = 6;
    localparam int ERR_CLOSED     = 0;
    localparam int ERR_REOPEN     = 1;
    localparam int ERR_REF_OPEN   = 2;
    localparam int ERR_TCCD       = 3;
    localparam int ERR_WREN_EMPTY = 4;
    localparam int ERR_WRQ_FULL   = 5;

    localparam int TCCD = 4;

endpackage

// File: rtl/ddr3_dfi_responder_if.sv
// DFI command/data bus between a DDR3 controller (master) and the responder (slave).
interface ddr3_dfi_responder_if
    import ddr3_dfi_responder_pkg::*;
#(
    parameter int DDR_ROW_BITS = 15,
    parameter int PHY_DAT_BITS = 32,
    parameter int PHY_STB_BITS = 4
) ();
    logic                      dfi_rst_ni;
    logic                      dfi_cke_i;
    logic                      dfi_cs_ni;
    logic                      dfi_ras_ni;
    logic                      dfi_cas_ni;
    logic                      dfi_we_ni;
    logic                      dfi_odt_i;
    logic [2:0]                dfi_bank_i;
    logic [DDR_ROW_BITS-1:0]   dfi_addr_i;
    logic                      dfi_wstb_i;
    logic                      dfi_wren_i;
    logic [PHY_STB_BITS-1:0]   dfi_mask_i;
    logic [PHY_DAT_BITS-1:0]   dfi_data_i;
    logic                      dfi_rvld_o;
    logic                      dfi_last_o;
    logic [PHY_DAT_BITS-1:0]   dfi_data_o;
    logic [ERR_BITS-1:0]       err_o;

    modport master (
        output dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni,
               dfi_odt_i, dfi_bank_i, dfi_addr_i, dfi_wstb_i, dfi_wren_i, dfi_mask_i,
               dfi_data_i,
        input  dfi_rvld_o, dfi_last_o, dfi_data_o, err_o
    );

    modport slave (
        input  dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni,
               dfi_odt_i, dfi_bank_i, dfi_addr_i, dfi_wstb_i, dfi_wren_i, dfi_mask_i,
               dfi_data_i,
        output dfi_rvld_o, dfi_last_o, dfi_data_o, err_o
    );

endinterface

// File: rtl/ddr3_resp_wrq.sv
// Small synchronous FIFO holding burst addresses of WR commands whose data
// beats have not yet arrived.
module ddr3_resp_wrq #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             arst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rdPtr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // Entry storage needs no reset: the count alone says which entries are live.
    always_ff @(posedge clock) begin
        if (w_push && !i_flush) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/ddr3_dfi_responder.sv
// DFI-side stand-in for a DDR3 PHY plus SDRAM: decodes commands, tracks open rows,
// stores write bursts on chip and replays read bursts after a fixed latency.
module ddr3_dfi_responder
    import ddr3_dfi_responder_pkg::*;
#(
    parameter int DDR_ROW_BITS = 15,
    parameter int DDR_COL_BITS = 10,
    parameter int PHY_DAT_BITS = 32,
    parameter int PHY_STB_BITS = 4,
    parameter int RD_LATENCY   = 8,
    parameter int WRQ_DEPTH    = 4,
    parameter int MEM_ABITS    = 12
) (
    input  logic clock,
    input  logic arst_n,
    ddr3_dfi_responder_if.slave dfi
);
    localparam int RSB       = DDR_ROW_BITS - 1;
    localparam int MSB       = PHY_DAT_BITS - 1;
    localparam int SSB       = PHY_STB_BITS - 1;
    localparam int CB_BITS   = DDR_COL_BITS - 3;
    localparam int FULL_BITS = 3 + DDR_ROW_BITS + CB_BITS;
    localparam int BA_BITS   = MEM_ABITS - 2;
    localparam int PIPE_LEN  = RD_LATENCY - 1;

    logic                 w_cmdValid;
    ddr_cmd_e             w_cmd;
    logic                 w_isAct, w_isPre, w_isRd, w_isWr, w_isRef;
    logic [2:0]           w_bank;
    logic                 w_a10;
    logic [7:0]           r_open;
    logic [RSB:0]         r_row [8];
    logic [FULL_BITS-1:0] w_fullBurst;
    logic [BA_BITS-1:0]   w_burst;
    logic                 w_wrqPush, w_wrqPop, w_wrqFull, w_wrqEmpty;
    logic [BA_BITS-1:0]   w_wrqHead;
    logic                 w_wrBeat;
    logic [1:0]           r_wrBeat;
    logic [MSB:0]         r_mem [2**MEM_ABITS];
    logic [PIPE_LEN-1:0]  r_pipeVld;
    logic [BA_BITS-1:0]   r_pipeAddr [PIPE_LEN];
    logic                 r_bActive;
    logic [BA_BITS-1:0]   r_bAddr;
    logic [1:0]           r_bBeat;
    logic                 w_pipeExit, w_issue, w_issueLast;
    logic [MEM_ABITS-1:0] w_issueAddr;
    logic                 r_rvld, r_last;
    logic [MSB:0]         r_data;
    logic [2:0]           r_rdGap;
    logic [ERR_BITS-1:0]  r_err, w_errSet;
    logic                 w_unused;

    assign w_cmdValid  = dfi.dfi_cke_i & ~dfi.dfi_cs_ni;
    assign w_cmd       = ddr_cmd_e'({dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni});
    assign w_isAct     = w_cmdValid && (w_cmd == CMD_ACT);
    assign w_isPre     = w_cmdValid && (w_cmd == CMD_PRE);
    assign w_isRd      = w_cmdValid && (w_cmd == CMD_RD);
    assign w_isWr      = w_cmdValid && (w_cmd == CMD_WR);
    assign w_isRef     = w_cmdValid && (w_cmd == CMD_REF);
    assign w_bank      = dfi.dfi_bank_i;
    assign w_a10       = dfi.dfi_addr_i[10];
    // Burst address uses the bank's row register even if the bank is closed.
    assign w_fullBurst = {w_bank, r_row[w_bank], dfi.dfi_addr_i[DDR_COL_BITS-1:3]};
    assign w_burst     = w_fullBurst[BA_BITS-1:0];
    assign w_unused    = ^{dfi.dfi_odt_i, dfi.dfi_wstb_i, w_fullBurst[FULL_BITS-1:BA_BITS]};

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            r_open <= '0;
            for (int i = 0; i < 8; i++) r_row[i] <= '0;
        end else if (!dfi.dfi_rst_ni) begin
            r_open <= '0;
        end else if (w_isAct) begin
            r_open[w_bank] <= 1'b1;
            r_row[w_bank]  <= dfi.dfi_addr_i;
        end else if (w_isPre) begin
            if (w_a10) r_open <= '0;
            else       r_open[w_bank] <= 1'b0;
        end else if ((w_isRd || w_isWr) && w_a10) begin
            r_open[w_bank] <= 1'b0;
        end
    end

    always_comb begin
        w_errSet = '0;
        w_errSet[ERR_CLOSED]     = (w_isRd | w_isWr) & ~r_open[w_bank];
        w_errSet[ERR_REOPEN]     = w_isAct & r_open[w_bank];
        w_errSet[ERR_REF_OPEN]   = w_isRef & (|r_open);
        w_errSet[ERR_TCCD]       = w_isRd & (r_rdGap < 3'(TCCD));
        w_errSet[ERR_WREN_EMPTY] = dfi.dfi_wren_i & w_wrqEmpty;
        w_errSet[ERR_WRQ_FULL]   = w_isWr & w_wrqFull;
    end

    // Gap counter saturates at tCCD so an idle bus never flags the next RD.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            r_err   <= '0;
            r_rdGap <= 3'(TCCD);
        end else begin
            r_err <= r_err | w_errSet;
            if (w_isRd)                    r_rdGap <= 3'd1;
            else if (r_rdGap < 3'(TCCD))   r_rdGap <= r_rdGap + 3'd1;
        end
    end

    assign w_wrqPush = w_isWr & ~w_wrqFull;
    assign w_wrBeat  = dfi.dfi_wren_i & ~w_wrqEmpty & dfi.dfi_rst_ni;
    assign w_wrqPop  = w_wrBeat & (r_wrBeat == 2'd3);

    ddr3_resp_wrq #(.DEPTH(WRQ_DEPTH), .WIDTH(BA_BITS)) u_wrq (
        .clock   (clock),
        .arst_n  (arst_n),
        .i_flush (~dfi.dfi_rst_ni),
        .i_push  (w_wrqPush),
        .i_data  (w_burst),
        .i_pop   (w_wrqPop),
        .o_head  (w_wrqHead),
        .o_full  (w_wrqFull),
        .o_empty (w_wrqEmpty)
    );

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n)                r_wrBeat <= '0;
        else if (!dfi.dfi_rst_ni)   r_wrBeat <= '0;
        else if (w_wrBeat)          r_wrBeat <= r_wrBeat + 2'd1;
    end

    always_ff @(posedge clock) begin
        if (w_wrBeat) begin
            for (int b = 0; b <= SSB; b++) begin
                if (!dfi.dfi_mask_i[b]) r_mem[{w_wrqHead, r_wrBeat}][8*b +: 8] <= dfi.dfi_data_i[8*b +: 8];
            end
        end
    end

    // Pipeline is one stage short of RD_LATENCY because the array read adds the last cycle.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            r_pipeVld <= '0;
            for (int i = 0; i < PIPE_LEN; i++) r_pipeAddr[i] <= '0;
        end else if (!dfi.dfi_rst_ni) begin
            r_pipeVld <= '0;
        end else begin
            r_pipeVld[0]  <= w_isRd;
            r_pipeAddr[0] <= w_burst;
            for (int i = 1; i < PIPE_LEN; i++) begin
                r_pipeVld[i]  <= r_pipeVld[i-1];
                r_pipeAddr[i] <= r_pipeAddr[i-1];
            end
        end
    end

    assign w_pipeExit  = r_pipeVld[PIPE_LEN-1];
    assign w_issue     = w_pipeExit | r_bActive;
    assign w_issueAddr = w_pipeExit ? {r_pipeAddr[PIPE_LEN-1], 2'b00} : {r_bAddr, r_bBeat};
    assign w_issueLast = ~w_pipeExit & r_bActive & (r_bBeat == 2'd3);

    // A new burst leaving the pipeline always takes over the read port.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            r_bActive <= 1'b0;
            r_bAddr   <= '0;
            r_bBeat   <= '0;
            r_rvld    <= 1'b0;
            r_last    <= 1'b0;
            r_data    <= '0;
        end else if (!dfi.dfi_rst_ni) begin
            r_bActive <= 1'b0;
            r_bBeat   <= '0;
            r_rvld    <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            if (w_pipeExit) begin
                r_bActive <= 1'b1;
                r_bAddr   <= r_pipeAddr[PIPE_LEN-1];
                r_bBeat   <= 2'd1;
            end else if (r_bActive) begin
                r_bBeat <= r_bBeat + 2'd1;
                if (r_bBeat == 2'd3) r_bActive <= 1'b0;
            end
            r_rvld <= w_issue;
            r_last <= w_issueLast;
            if (w_issue) r_data <= r_mem[w_issueAddr];
        end
    end

    assign dfi.dfi_rvld_o = r_rvld;
    assign dfi.dfi_last_o = r_last;
    assign dfi.dfi_data_o = r_data;
    assign dfi.err_o      = r_err;

endmodule

// File: tb/tb_ddr3_dfi_responder.sv
// Directed bench for ddr3_dfi_responder: a table of write/read-back bursts plus
// hand-written sequences for read spacing, error flags and mid-burst resets.
module tb_ddr3_dfi_responder;
    import ddr3_dfi_responder_pkg::*;

    localparam int RD_LAT = 8;

    typedef struct {
        logic [2:0]  bank;
        logic [14:0] row;
        logic [9:0]  col;
        logic [31:0] wdata [4];
        logic [3:0]  mask  [4];
        logic [31:0] rdata [4];
    } vec_t;

    logic clock  = 1'b0;
    logic arst_n = 1'b0;
    int   checkCount = 0;
    int   errorCount = 0;
    vec_t vecs [6];
    logic [31:0] expBurst [4];

    always #5 clock = ~clock;

    ddr3_dfi_responder_if #(.DDR_ROW_BITS(15), .PHY_DAT_BITS(32), .PHY_STB_BITS(4)) dfi ();

    ddr3_dfi_responder #(
        .DDR_ROW_BITS (15),
        .DDR_COL_BITS (10),
        .PHY_DAT_BITS (32),
        .PHY_STB_BITS (4),
        .RD_LATENCY   (RD_LAT),
        .WRQ_DEPTH    (4),
        .MEM_ABITS    (12)
    ) dut (
        .clock  (clock),
        .arst_n (arst_n),
        .dfi    (dfi)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one bus cycle at the falling edge, then returns the bus to idle.
    task automatic applyStimulus(input ddr_cmd_e cmd, input logic [2:0] bank, input logic [14:0] addr,
                                 input logic wren, input logic [3:0] mask, input logic [31:0] data);
        dfi.dfi_cs_ni = 1'b0;
        {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni} = cmd;
        dfi.dfi_bank_i = bank;
        dfi.dfi_addr_i = addr;
        dfi.dfi_wren_i = wren;
        dfi.dfi_mask_i = mask;
        dfi.dfi_data_i = data;
        @(negedge clock);
        {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni} = CMD_NOP;
        dfi.dfi_wren_i = 1'b0;
    endtask

    task automatic doCmd(input ddr_cmd_e cmd, input logic [2:0] bank, input logic [14:0] addr);
        applyStimulus(cmd, bank, addr, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic doBeat(input logic [3:0] mask, input logic [31:0] data);
        applyStimulus(CMD_NOP, 3'd0, 15'h0, 1'b1, mask, data);
    endtask

    // Called right after the RD cycle; checks silence one cycle early, then all four beats.
    task automatic checkBurst(input string name, input logic [31:0] exp [4]);
        repeat (RD_LAT - 2) @(negedge clock);
        checkOutput({name, " rvld before latency"}, {31'b0, dfi.dfi_rvld_o}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            checkOutput($sformatf("%s rvld beat%0d", name, b), {31'b0, dfi.dfi_rvld_o}, 32'd1);
            checkOutput($sformatf("%s last beat%0d", name, b), {31'b0, dfi.dfi_last_o}, {31'b0, b == 3});
            checkOutput($sformatf("%s data beat%0d", name, b), dfi.dfi_data_o, exp[b]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{3'd2, 15'h15, 10'h008,
                    '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                    '{4'h0, 4'h0, 4'h0, 4'h0},
                    '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}};
        vecs[1] = '{3'd2, 15'h15, 10'h008,
                    '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA},
                    '{4'b0101, 4'hF, 4'hF, 4'hF},
                    '{32'hAA11AA11, 32'h22222222, 32'h33333333, 32'h44444444}};
        vecs[2] = '{3'd7, 15'h1, 10'h3F8,
                    '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEF00D},
                    '{4'h0, 4'h0, 4'h0, 4'h0},
                    '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEF00D}};
        vecs[3] = '{3'd7, 15'h1, 10'h3FF,
                    '{32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555},
                    '{4'b1110, 4'b0111, 4'hF, 4'h0},
                    '{32'h01234555, 32'h55ABCDEF, 32'hDEADBEEF, 32'h55555555}};
        vecs[4] = '{3'd3, 15'h8, 10'h000,
                    '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3},
                    '{4'h0, 4'h0, 4'h0, 4'h0},
                    '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3}};
        vecs[5] = '{3'd4, 15'h10, 10'h000,
                    '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                    '{4'hF, 4'hF, 4'hF, 4'hF},
                    '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3}};

        dfi.dfi_rst_ni = 1'b1;
        dfi.dfi_cke_i  = 1'b1;
        dfi.dfi_cs_ni  = 1'b1;
        {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni} = CMD_NOP;
        dfi.dfi_odt_i  = 1'b0;
        dfi.dfi_wstb_i = 1'b0;
        dfi.dfi_bank_i = '0;
        dfi.dfi_addr_i = '0;
        dfi.dfi_wren_i = 1'b0;
        dfi.dfi_mask_i = '0;
        dfi.dfi_data_i = '0;

        repeat (2) @(negedge clock);
        checkOutput("reset rvld", {31'b0, dfi.dfi_rvld_o}, 32'd0);
        checkOutput("reset last", {31'b0, dfi.dfi_last_o}, 32'd0);
        checkOutput("reset data", dfi.dfi_data_o, 32'd0);
        checkOutput("reset err",  {26'b0, dfi.err_o}, 32'd0);
        arst_n = 1'b1;
        @(negedge clock);

        // Table: open, write a burst, read it back with auto-precharge.
        for (int v = 0; v < 6; v++) begin
            doCmd(CMD_ACT, vecs[v].bank, vecs[v].row);
            doCmd(CMD_NOP, 3'd0, 15'h0);
            doCmd(CMD_WR, vecs[v].bank, {5'b0, vecs[v].col});
            for (int b = 0; b < 4; b++) doBeat(vecs[v].mask[b], vecs[v].wdata[b]);
            doCmd(CMD_RD, vecs[v].bank, {5'b00001, vecs[v].col});
            checkBurst($sformatf("vec%0d", v), vecs[v].rdata);
        end
        checkOutput("table err", {26'b0, dfi.err_o}, 32'd0);

        // Two RDs exactly tCCD apart stream eight contiguous beats.
        doCmd(CMD_ACT, 3'd2, 15'h15);
        doCmd(CMD_NOP, 3'd0, 15'h0);
        doCmd(CMD_RD, 3'd2, 15'h008);
        repeat (3) doCmd(CMD_NOP, 3'd0, 15'h0);
        doCmd(CMD_RD, 3'd2, 15'h408);
        repeat (RD_LAT - 6) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checkOutput($sformatf("gapless rvld %0d", i), {31'b0, dfi.dfi_rvld_o}, 32'd1);
            checkOutput($sformatf("gapless last %0d", i), {31'b0, dfi.dfi_last_o}, {31'b0, (i % 4) == 3});
            checkOutput($sformatf("gapless data %0d", i), dfi.dfi_data_o, vecs[1].rdata[i % 4]);
        end
        @(negedge clock);
        checkOutput("gapless rvld after", {31'b0, dfi.dfi_rvld_o}, 32'd0);
        checkOutput("gapless err", {26'b0, dfi.err_o}, 32'd0);

        // RDs three cycles apart violate tCCD.
        doCmd(CMD_ACT, 3'd2, 15'h15);
        doCmd(CMD_NOP, 3'd0, 15'h0);
        doCmd(CMD_RD, 3'd2, 15'h008);
        repeat (2) doCmd(CMD_NOP, 3'd0, 15'h0);
        doCmd(CMD_RD, 3'd2, 15'h408);
        repeat (RD_LAT + 6) @(negedge clock);
        checkOutput("tccd err", {26'b0, dfi.err_o}, 32'h08);

        // Bank-state violations and refresh checks.
        doCmd(CMD_RD, 3'd5, 15'h008);
        repeat (RD_LAT + 6) @(negedge clock);
        checkOutput("closed bank err", {26'b0, dfi.err_o}, 32'h09);
        doCmd(CMD_ACT, 3'd1, 15'h3);
        doCmd(CMD_ACT, 3'd1, 15'h4);
        checkOutput("reopen err", {26'b0, dfi.err_o}, 32'h0B);
        doCmd(CMD_PRE, 3'd0, 15'h400);
        doCmd(CMD_REF, 3'd0, 15'h0);
        checkOutput("ref after pre-all err", {26'b0, dfi.err_o}, 32'h0B);
        doCmd(CMD_ACT, 3'd6, 15'h2);
        doCmd(CMD_REF, 3'd0, 15'h0);
        checkOutput("ref with open bank err", {26'b0, dfi.err_o}, 32'h0F);
        doCmd(CMD_PRE, 3'd0, 15'h400);

        // Overfill the write queue, drain it, then send one beat too many.
        doCmd(CMD_ACT, 3'd2, 15'h15);
        for (int i = 0; i < 5; i++) doCmd(CMD_WR, 3'd2, 15'(32'h010 + 8 * i));
        checkOutput("wrq full err", {26'b0, dfi.err_o}, 32'h2F);
        for (int i = 0; i < 16; i++) doBeat(4'h0, 32'h1000 + i);
        checkOutput("drain no empty err", {26'b0, dfi.err_o}, 32'h2F);
        doBeat(4'h0, 32'hDEAD0000);
        checkOutput("wren empty err", {26'b0, dfi.err_o}, 32'h3F);
        expBurst = '{32'h1000, 32'h1001, 32'h1002, 32'h1003};
        doCmd(CMD_RD, 3'd2, 15'h010);
        checkBurst("wrq entry0", expBurst);
        expBurst = '{32'h100C, 32'h100D, 32'h100E, 32'h100F};
        doCmd(CMD_RD, 3'd2, 15'h428);
        checkBurst("wrq entry3", expBurst);

        // Asynchronous reset in the middle of a read burst.
        doCmd(CMD_ACT, 3'd2, 15'h15);
        doCmd(CMD_RD, 3'd2, 15'h408);
        repeat (RD_LAT - 1) @(negedge clock);
        checkOutput("arst pre rvld", {31'b0, dfi.dfi_rvld_o}, 32'd1);
        @(negedge clock);
        arst_n = 1'b0;
        #1;
        checkOutput("arst rvld", {31'b0, dfi.dfi_rvld_o}, 32'd0);
        checkOutput("arst err",  {26'b0, dfi.err_o}, 32'd0);
        @(negedge clock);
        arst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checkOutput($sformatf("arst no last %0d", i), {30'b0, dfi.dfi_last_o, dfi.dfi_rvld_o}, 32'd0);
        end

        // DDR reset aborts an in-flight burst and closes all banks.
        doCmd(CMD_ACT, 3'd2, 15'h15);
        doCmd(CMD_RD, 3'd2, 15'h008);
        repeat (RD_LAT - 1) @(negedge clock);
        checkOutput("dfirst pre rvld", {31'b0, dfi.dfi_rvld_o}, 32'd1);
        dfi.dfi_rst_ni = 1'b0;
        @(negedge clock);
        dfi.dfi_rst_ni = 1'b1;
        checkOutput("dfirst rvld", {31'b0, dfi.dfi_rvld_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput($sformatf("dfirst no last %0d", i), {30'b0, dfi.dfi_last_o, dfi.dfi_rvld_o}, 32'd0);
        end
        doCmd(CMD_RD, 3'd2, 15'h008);
        checkOutput("dfirst bank closed err", {26'b0, dfi.err_o}, 32'h01);
        repeat (RD_LAT + 6) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
